// File: rtl/mul_pkg.sv
// ---------------------------------------------------------------------------
// mul_pkg
// Shared definitions for the sequential Booth multiplier datapath:
// operand width, iteration counter width, last-iteration index and the
// controller state encoding.
// ---------------------------------------------------------------------------
package mul_pkg;

    localparam int MUL_W     = 32;
    localparam int MUL_CNT_W = 5;

    // Index of the final Booth iteration (32 steps numbered 0..31).
    localparam logic [MUL_CNT_W-1:0] MUL_LAST = 5'd31;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/cla32.sv
// ---------------------------------------------------------------------------
// cla32
// 32-bit carry-lookahead adder built from eight 4-bit lookahead groups.
// Each group resolves its internal carries in parallel from generate and
// propagate terms; group carries are chained through the group-level
// generate/propagate pair.
//
// Ports:
//   a_i  [31:0]  addend
//   b_i  [31:0]  addend
//   ci_i         carry in
//   s_o  [31:0]  sum
//   co_o         carry out of bit 31
// ---------------------------------------------------------------------------
module cla32 (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        ci_i,
    output logic [31:0] s_o,
    output logic        co_o
);

    logic [31:0] g;
    logic [31:0] p;
    logic [31:0] c;
    logic [8:0]  gc;

    assign g     = a_i & b_i;
    assign p     = a_i ^ b_i;
    assign gc[0] = ci_i;

    for (genvar i = 0; i < 8; i++) begin : g_grp
        localparam int B = 4 * i;
        logic grpG;
        logic grpP;

        // In-group carries expanded so every bit sees the group carry-in directly.
        assign c[B]   = gc[i];
        assign c[B+1] = g[B] | (p[B] & gc[i]);
        assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & gc[i]);
        assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                      | (p[B+2] & p[B+1] & p[B] & gc[i]);

        assign grpG = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                    | (p[B+3] & p[B+2] & p[B+1] & g[B]);
        assign grpP = p[B+3] & p[B+2] & p[B+1] & p[B];

        assign gc[i+1] = grpG | (grpP & gc[i]);
    end

    assign s_o  = p ^ c;
    assign co_o = gc[8];

endmodule

// File: rtl/booth_mul32.sv
// ---------------------------------------------------------------------------
// booth_mul32
// Sequential radix-2 Booth multiplier: signed 32 x 32 -> signed 64 in 32
// iteration cycles. One Booth step per cycle through a shared cla32 adder,
// followed by an arithmetic right shift of {A, Q, q_m1}.
//
// Ports:
//   clk           rising-edge clock
//   reset_n       asynchronous active-low reset
//   op_start      begin a multiply (accepted in IDLE and DONE only)
//   op_clear      abort/clear to IDLE with a zero result (beats op_start)
//   multiplicand  signed operand M, captured on the accepting edge
//   multiplier    signed operand Q, captured on the accepting edge
//   result        {A, Q}; meaningful while op_done is high
//   op_busy       high while iterating
//   op_done       high while holding a finished product
// ---------------------------------------------------------------------------
module booth_mul32
    import mul_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 op_start,
    input  logic                 op_clear,
    input  logic [MUL_W-1:0]     multiplicand,
    input  logic [MUL_W-1:0]     multiplier,
    output logic [2*MUL_W-1:0]   result,
    output logic                 op_busy,
    output logic                 op_done
);

    mul_state_e           state_q, state_d;
    logic [MUL_W-1:0]     m_q, m_d;
    logic [MUL_W-1:0]     a_q, a_d;
    logic [MUL_W-1:0]     q_q, q_d;
    logic                 qm1_q, qm1_d;
    logic [MUL_CNT_W-1:0] cnt_q, cnt_d;

    logic [MUL_W-1:0]     b_eff;
    logic                 sub;
    logic [MUL_W-1:0]     sum;
    logic                 cla_co_unused;
    logic                 ovf;
    logic                 sgn;

    // Booth recoding of the current multiplier bit pair into adder operands.
    always_comb begin
        b_eff = '0;
        sub   = 1'b0;
        unique case ({q_q[0], qm1_q})
            2'b01: b_eff = m_q;
            2'b10: begin
                b_eff = ~m_q;
                sub   = 1'b1;
            end
            default: b_eff = '0;
        endcase
    end

    cla32 u_cla (
        .a_i  (a_q),
        .b_i  (b_eff),
        .ci_i (sub),
        .s_o  (sum),
        .co_o (cla_co_unused)
    );

    // The shift needs the sum's true sign, i.e. a 33rd bit. When the add
    // overflows, s[31] is the inverse of that sign, which matters for
    // M = 0x8000_0000 where A - M leaves the 32-bit range.
    assign ovf = (a_q[MUL_W-1] == b_eff[MUL_W-1]) & (sum[MUL_W-1] != a_q[MUL_W-1]);
    assign sgn = sum[MUL_W-1] ^ ovf;

    // Controller and datapath next state. Clear has top priority; a start
    // loads fresh operands only from IDLE or DONE.
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        a_d     = a_q;
        q_d     = q_q;
        qm1_d   = qm1_q;
        cnt_d   = cnt_q;

        if (op_clear) begin
            state_d = IDLE;
            a_d     = '0;
            q_d     = '0;
            qm1_d   = 1'b0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (op_start) begin
                        state_d = EXEC;
                        m_d     = multiplicand;
                        a_d     = '0;
                        q_d     = multiplier;
                        qm1_d   = 1'b0;
                        cnt_d   = '0;
                    end
                end
                EXEC: begin
                    a_d   = {sgn, sum[MUL_W-1:1]};
                    q_d   = {sum[0], q_q[MUL_W-1:1]};
                    qm1_d = q_q[0];
                    if (cnt_q == MUL_LAST) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            m_q     <= '0;
            a_q     <= '0;
            q_q     <= '0;
            qm1_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            a_q     <= a_d;
            q_q     <= q_d;
            qm1_q   <= qm1_d;
            cnt_q   <= cnt_d;
        end
    end

    assign result  = {a_q, q_q};
    assign op_busy = (state_q == EXEC);
    assign op_done = (state_q == DONE);

endmodule

// File: tb/tb_booth_mul32.sv
// ---------------------------------------------------------------------------
// tb_booth_mul32
// Self-checking bench for booth_mul32. A product-level model predicts
// busy/done/result from the handshake rules and signed 64-bit arithmetic;
// a compare process checks the DUT on every falling edge, and directed
// cases pin literal products, latency, aborts and reset behaviour.
// ---------------------------------------------------------------------------
module tb_booth_mul32;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        op_start;
    logic        op_clear;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic [63:0] result;
    logic        op_busy;
    logic        op_done;

    int total = 0;
    int bad   = 0;

    // Model: 0 = idle, 1 = multiplying, 2 = product available.
    int          mState = 0;
    int          mLeft  = 0;
    logic [63:0] mProd  = '0;

    always #5 clk = ~clk;

    booth_mul32 dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .op_start     (op_start),
        .op_clear     (op_clear),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .result       (result),
        .op_busy      (op_busy),
        .op_done      (op_done)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%016h expected 0x%016h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Reference behaviour: a multiply takes 32 edges after acceptance and
    // yields the plain signed 64-bit product.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mState = 0;
            mLeft  = 0;
            mProd  = '0;
        end else if (op_clear) begin
            mState = 0;
        end else begin
            case (mState)
                0, 2: if (op_start) begin
                    mProd  = 64'(longint'($signed(multiplicand)) * longint'($signed(multiplier)));
                    mState = 1;
                    mLeft  = 32;
                end
                1: begin
                    mLeft--;
                    if (mLeft == 0) mState = 2;
                end
                default: mState = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        checkOutput("busy", 64'(op_busy), 64'(mState == 1));
        checkOutput("done", 64'(op_done), 64'(mState == 2));
        if (mState == 0)      checkOutput("idleResult", result, 64'd0);
        else if (mState == 2) checkOutput("product", result, mProd);
    end

    // Present operands with op_start for exactly one rising edge.
    task automatic applyStimulus(input logic [31:0] m, input logic [31:0] q);
        @(posedge clk); #1;
        multiplicand = m;
        multiplier   = q;
        op_start     = 1'b1;
        @(posedge clk); #1;
        op_start     = 1'b0;
        multiplicand = $urandom;
        multiplier   = $urandom;
    endtask

    // Counts falling edges from the accepting edge until done (bounded).
    task automatic waitDone(output int lat, output int busyCnt);
        lat     = -1;
        busyCnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (op_done) begin
                lat = i;
                break;
            end
            if (op_busy) busyCnt++;
        end
    endtask

    task automatic runDirected(input string name, input logic [31:0] m,
                               input logic [31:0] q, input logic [63:0] expected);
        int lat, busyCnt;
        applyStimulus(m, q);
        waitDone(lat, busyCnt);
        checkOutput({name, " latency"}, 64'(lat), 64'd32);
        checkOutput({name, " busyCycles"}, 64'(busyCnt), 64'd32);
        checkOutput(name, result, expected);
    endtask

    initial begin
        int lat, busyCnt, doneCnt, period;
        reset_n      = 1'b0;
        op_start     = 1'b0;
        op_clear     = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        repeat (3) @(negedge clk);
        checkOutput("resetResult", result, 64'd0);
        checkOutput("resetFlags", 64'({op_busy, op_done}), 64'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        runDirected("7x3",        32'd7,          32'd3,          64'h0000_0000_0000_0015);
        runDirected("-5x3",       32'hFFFF_FFFB,  32'd3,          64'hFFFF_FFFF_FFFF_FFF1);
        runDirected("-1x-1",      32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'h0000_0000_0000_0001);
        runDirected("0xN",        32'd0,          32'h1234_5678,  64'd0);
        runDirected("minxmin",    32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000);
        runDirected("maxxmin",    32'h7FFF_FFFF,  32'h8000_0000,  64'hC000_0000_8000_0000);

        // Start pulsed mid-multiply must not disturb the running product.
        applyStimulus(32'd1000, 32'hFFFF_FFFD);
        repeat (10) @(negedge clk);
        @(posedge clk); #1;
        multiplicand = 32'd5;
        multiplier   = 32'd5;
        op_start     = 1'b1;
        @(posedge clk); #1;
        op_start     = 1'b0;
        waitDone(lat, busyCnt);
        checkOutput("ignoredStart doneSeen", 64'(lat >= 0), 64'd1);
        checkOutput("ignoredStart product", result, 64'hFFFF_FFFF_FFFF_F448);

        // Clear mid-multiply: back to idle with zero result, no done.
        applyStimulus(32'd123, 32'd456);
        repeat (10) @(negedge clk);
        @(posedge clk); #1;
        op_clear = 1'b1;
        @(posedge clk); #1;
        op_clear = 1'b0;
        checkOutput("clear flags", 64'({op_busy, op_done}), 64'd0);
        checkOutput("clear result", result, 64'd0);
        doneCnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (op_done) doneCnt++;
        end
        checkOutput("clear noDone", 64'(doneCnt), 64'd0);

        // Clear and start together while holding a product: clear wins.
        runDirected("2x3", 32'd2, 32'd3, 64'd6);
        @(posedge clk); #1;
        op_clear = 1'b1;
        op_start = 1'b1;
        @(posedge clk); #1;
        op_clear = 1'b0;
        op_start = 1'b0;
        checkOutput("clearStart flags", 64'({op_busy, op_done}), 64'd0);
        checkOutput("clearStart result", result, 64'd0);

        // Asynchronous reset in the middle of a multiply.
        applyStimulus(32'd99, 32'd77);
        repeat (20) @(negedge clk);
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        checkOutput("asyncReset result", result, 64'd0);
        checkOutput("asyncReset flags", 64'({op_busy, op_done}), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        runDirected("6x7", 32'd6, 32'd7, 64'd42);

        // Back-to-back random products with op_start held high.
        @(posedge clk); #1;
        multiplicand = $urandom;
        multiplier   = $urandom;
        op_start     = 1'b1;
        @(posedge clk); #1;
        for (int n = 0; n < 1200; n++) begin
            period = -1;
            for (int i = 1; i <= 40; i++) begin
                @(negedge clk);
                if (op_done) begin
                    period = i;
                    break;
                end
            end
            checkOutput("b2b period", 64'(period), 64'd33);
            if (period < 0) break;
            multiplicand = $urandom;
            multiplier   = $urandom;
        end
        op_start = 1'b0;
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
